ps2_scancode_decoder: RTL

Consumes the raw scancode byte stream produced by the PS/2 keyboard controller and turns it into complete key events: make or break, extended or normal, with an optional ASCII translation. Events are buffered in a small FIFO and drained by a valid/ready consumer, such as the 7-segment display path or a CPU-mapped keyboard register. It sits directly downstream of the keyboard controller, on the same system clock.

---
 rtl/ps2_pkg.sv | 69 ++++++
 rtl/event_fifo.sv | 53 +++++
 rtl/ps2_scancode_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode decoder.
// The ASCII lookup is only used when SCANCODE_ASCII_EN is defined.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } state_e;

  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeBrk    = 8'hF0;
  localparam logic [7:0] RespBat    = 8'hAA;
  localparam logic [7:0] RespAck    = 8'hFA;
  localparam logic [7:0] RespEcho   = 8'hEE;
  localparam logic [7:0] RespResend = 8'hFE;
  localparam logic [7:0] RespErr0   = 8'h00;
  localparam logic [7:0] RespErrF   = 8'hFF;
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } evt_t;

  // Keyboard responses that never start or finish a key sequence.
  function automatic logic is_response(input logic [7:0] code);
    return (code == RespBat) || (code == RespAck) || (code == RespEcho) ||
           (code == RespResend) || (code == RespErr0) || (code == RespErrF);
  endfunction

  // Set-2 scancode to ASCII; letters are upper-cased when shift is held.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] lower;
    logic       letter;
    lower  = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      return shift ? (lower - 8'h20) : lower;
    end
    case (code)
      8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
      8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;
      8'h3D: return 8'h37;  8'h3E: return 8'h38;  8'h46: return 8'h39;
      8'h45: return 8'h30;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle. Depth must be a power of two (>= 2).
module event_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  output logic                       accept_o,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o   = (count_q == CntW'(Depth));
  assign empty_o  = (count_q == '0);
  assign pop_ok   = pop_i && !empty_o;
  assign push_ok  = push_i && (!full_o || pop_ok);
  assign accept_o = push_ok;
  assign rdata_o  = mem_q[rptr_q];
  assign count_o  = count_q;

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns a PS/2 set-2 scancode byte stream into make/break key events queued
// in a show-ahead FIFO. Define SCANCODE_ASCII_EN to build the ASCII ROM;
// otherwise EVT_ASCII is 0 and no ascii bits are stored.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    CODE,
  input  logic                          CODE_VALID,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [7:0]                    EVT_CODE,
  output logic                          EVT_EXT,
  output logic                          EVT_BREAK,
  output logic [7:0]                    EVT_ASCII,
  output logic                          SHIFT,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SCANCODE_ASCII_EN
  localparam int unsigned EvtW = 18;
`else
  localparam int unsigned EvtW = 10;
`endif

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            ovf_q, ovf_d;

  logic            emit, emit_ext, emit_brk;
  logic [7:0]      emit_ascii;
  logic [EvtW-1:0] fifo_wdata, fifo_rdata;
  logic            fifo_accept, fifo_full, fifo_empty, fifo_pop;

  // Prefix parser, timeout counter and shift tracking.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;

    if (CODE_VALID) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (CODE == CodeExt)          state_d = StExt;
          else if (CODE == CodeBrk)     state_d = StBrk;
          else if (!is_response(CODE))  emit = 1'b1;
        end
        StExt: begin
          if (CODE == CodeBrk)          state_d = StExtBrk;
          else if (CODE != CodeExt) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          if (CODE == CodeExt)          state_d = StExtBrk;
          else if (CODE != CodeBrk) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
        StExtBrk: begin
          if ((CODE != CodeExt) && (CODE != CodeBrk)) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
      // Abandon a stale prefix without emitting anything.
      tmo_d   = '0;
      state_d = StIdle;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // Shift state follows the key even if the event is later dropped.
    if (emit && !emit_ext) begin
      if (CODE == CodeLShift) lshift_d = !emit_brk;
      if (CODE == CodeRShift) rshift_d = !emit_brk;
    end
  end

  // ASCII lookup uses the shift state from before this event.
  always_comb begin
`ifdef SCANCODE_ASCII_EN
    emit_ascii = (!emit_ext && !emit_brk) ? scan_to_ascii(CODE, SHIFT) : 8'h00;
    fifo_wdata = {emit_ext, emit_brk, CODE, emit_ascii};
`else
    emit_ascii = 8'h00;
    fifo_wdata = {emit_ext, emit_brk, CODE};
`endif
  end

  // Overflow is sticky until reset.
  always_comb begin
    ovf_d = ovf_q;
    if (emit && !fifo_accept) ovf_d = 1'b1;
  end

  // Parser and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_pop = EVT_VALID && EVT_READY;

  event_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EvtW)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .push_i   (emit),
    .wdata_i  (fifo_wdata),
    .accept_o (fifo_accept),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (FIFO_COUNT)
  );

  // Head fields are forced to 0 while empty so outputs are defined after reset.
  always_comb begin
    EVT_VALID = !fifo_empty;
    EVT_EXT   = 1'b0;
    EVT_BREAK = 1'b0;
    EVT_CODE  = 8'h00;
    EVT_ASCII = 8'h00;
    if (EVT_VALID) begin
`ifdef SCANCODE_ASCII_EN
      EVT_EXT   = fifo_rdata[17];
      EVT_BREAK = fifo_rdata[16];
      EVT_CODE  = fifo_rdata[15:8];
      EVT_ASCII = fifo_rdata[7:0];
`else
      EVT_EXT   = fifo_rdata[9];
      EVT_BREAK = fifo_rdata[8];
      EVT_CODE  = fifo_rdata[7:0];
`endif
    end
  end

  assign SHIFT    = lshift_q || rshift_q;
  assign OVERFLOW = ovf_q;

  // Full is implied by accept; kept for observability of the FIFO interface.
  logic unused_full;
  assign unused_full = fifo_full ^ (|emit_ascii);

endmodule
